sprite_bitmap_ram: RTL

Double-buffered 16x16 sprite bitmap store that serves the row-fetch port of `sprite_renderer`. The store drives `rom_bits` from `rom_addr` and replaces the fixed `car_bitmap` ROM. A byte-stream writer, such as a UART or SPI loader, fills a hidden back bank. The banks swap only at a frame tick while no sprite is being drawn, so a sprite never tears mid-frame.

---
 rtl/sprite_bitmap_ram_if.sv | 10 +
 rtl/sprite_bitmap_ram.sv | 108 ++++++++++
 2 files changed

// File: rtl/sprite_bitmap_ram_if.sv
// rtl/sprite_bitmap_ram_if.sv - byte-stream loader port for the sprite bitmap store
interface sprite_bitmap_ram_if;
  logic [7:0] wr_data;
  logic       wr_sof;
  logic       wr_valid;
  logic       wr_ready;

  modport master (output wr_data, output wr_sof, output wr_valid, input wr_ready);
  modport slave  (input wr_data, input wr_sof, input wr_valid, output wr_ready);
endinterface

// File: rtl/sprite_bitmap_ram.sv
// rtl/sprite_bitmap_ram.sv - double-buffered 16x16 sprite bitmap, loader fills back bank, swap on frame tick
module sprite_bitmap_ram (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                rom_addr,
  output logic [15:0]               rom_bits,
  sprite_bitmap_ram_if.slave        wr,
  input  logic                      frame_tick,
  input  logic                      in_progress,
  output logic                      swapped,
  output logic                      wr_error
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, FULL} state_t;

  state_t      state, state_next;
  logic [3:0]  row, row_next, wr_row;
  logic        front, front_next;
  logic        wr_lo, wr_hi;
  logic        err_next, swap_next;
  logic        accept;
  logic [15:0] bank [2][16];

  // Ready depends only on state and reset so the loader never sees a combinational loop.
  assign wr.wr_ready = !reset && (state != FULL);
  assign accept      = wr.wr_valid && wr.wr_ready;
  assign rom_bits    = bank[front][rom_addr];

  always_comb begin
    state_next = state;
    row_next   = row;
    front_next = front;
    wr_row     = row;
    wr_lo      = 1'b0;
    wr_hi      = 1'b0;
    err_next   = 1'b0;
    swap_next  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (wr.wr_sof) begin
            wr_lo      = 1'b1;
            wr_row     = 4'd0;
            row_next   = 4'd0;
            state_next = HIGH;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      LOW, HIGH: begin
        if (accept) begin
          if (wr.wr_sof) begin
            // Restart: stale rows stay behind but are unreachable until 32 fresh bytes arrive.
            wr_lo      = 1'b1;
            wr_row     = 4'd0;
            row_next   = 4'd0;
            state_next = HIGH;
            err_next   = 1'b1;
          end else if (state == LOW) begin
            wr_lo      = 1'b1;
            state_next = HIGH;
          end else begin
            wr_hi = 1'b1;
            if (row == 4'd15) begin
              state_next = FULL;
            end else begin
              row_next   = row + 4'd1;
              state_next = LOW;
            end
          end
        end
      end
      FULL: begin
        if (frame_tick && !in_progress) begin
          front_next = !front;
          swap_next  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      row      <= 4'd0;
      front    <= 1'b0;
      swapped  <= 1'b0;
      wr_error <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 16; r++) begin
          bank[b][r] <= 16'h0000;
        end
      end
    end else begin
      state    <= state_next;
      row      <= row_next;
      front    <= front_next;
      swapped  <= swap_next;
      wr_error <= err_next;
      if (wr_lo) bank[!front][wr_row][7:0]  <= wr.wr_data;
      if (wr_hi) bank[!front][wr_row][15:8] <= wr.wr_data;
    end
  end

endmodule
